// File: rtl/tawas_regfile_mt_if.sv
// Bundled load and writeback signals of the multithreaded register file.
// The master drives requests and writebacks; the slave returns the loaded context and status.
interface tawas_regfile_mt_if #(
  parameter int unsigned THREADS  = 16,
  parameter int unsigned REGS     = 8,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned FLAGW    = 8,
  parameter int unsigned WB_PORTS = 3
);
  localparam int unsigned TW = $clog2(THREADS);
  localparam int unsigned RW = $clog2(REGS);

  logic                     init_done;
  logic                     thread_start_en;
  logic [TW-1:0]            thread_start;
  logic [REGS*XLEN-1:0]     regdata;
  logic [FLAGW-1:0]         au_flags;
  logic                     regdata_vld;
  logic [TW-1:0]            wb_thread;
  logic [WB_PORTS-1:0]      wb_en;
  logic [WB_PORTS*RW-1:0]   wb_reg;
  logic [WB_PORTS*XLEN-1:0] wb_data;
  logic                     wb_flags_en;
  logic [FLAGW-1:0]         wb_flags;
  logic                     wb_conflict;

  modport master (
    output thread_start_en, thread_start, wb_thread, wb_en, wb_reg, wb_data,
           wb_flags_en, wb_flags,
    input  init_done, regdata, au_flags, regdata_vld, wb_conflict
  );

  modport slave (
    input  thread_start_en, thread_start, wb_thread, wb_en, wb_reg, wb_data,
           wb_flags_en, wb_flags,
    output init_done, regdata, au_flags, regdata_vld, wb_conflict
  );
endinterface

// File: rtl/tawas_regfile_mt.sv
// Per-thread register/flag contexts with a post-reset clear sequence,
// merged multi-port writeback through a one-deep write stage, and bypassed context loads.
module tawas_regfile_mt #(
  parameter int unsigned THREADS  = 16,
  parameter int unsigned REGS     = 8,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned FLAGW    = 8,
  parameter int unsigned WB_PORTS = 3
) (
  input logic               clk,
  input logic               rst,
  tawas_regfile_mt_if.slave bus
);
  localparam int unsigned TW  = $clog2(THREADS);
  localparam int unsigned RW  = $clog2(REGS);
  localparam int unsigned RDW = REGS * XLEN;
  localparam int unsigned EW  = FLAGW + RDW;

  typedef enum logic {INIT, RUN} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] cnt, cnt_nxt;
  logic          done_nxt;

  logic [EW-1:0] mem [THREADS];

  logic          run_c;
  logic          wr_c;
  logic          conflict_c;
  logic [EW-1:0] merge_data_c, merge_mask_c, bypass_c;

  logic          wen;
  logic [TW-1:0] waddr;
  logic [EW-1:0] wdata, wmask;

  // Clear-sequence state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= INIT;
      cnt           <= '0;
      bus.init_done <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bus.init_done <= done_nxt;
    end
  end

  // Walk the clear counter over every thread, then settle in RUN
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = bus.init_done;
    case (state)
      INIT: begin
        cnt_nxt = cnt + TW'(1);
        if (cnt == TW'(THREADS - 1)) begin
          state_nxt = RUN;
          done_nxt  = 1'b1;
          cnt_nxt   = '0;
        end
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  assign run_c = (state == RUN);
  assign wr_c  = run_c && ((|bus.wb_en) || bus.wb_flags_en);

  // Writeback merge: later ports overwrite earlier ones on a shared register
  always_comb begin
    merge_data_c = '0;
    merge_mask_c = '0;
    conflict_c   = 1'b0;
    for (int p = 0; p < int'(WB_PORTS); p++) begin
      if (bus.wb_en[p]) begin
        merge_data_c[int'(bus.wb_reg[p*RW +: RW])*XLEN +: XLEN] = bus.wb_data[p*XLEN +: XLEN];
        merge_mask_c[int'(bus.wb_reg[p*RW +: RW])*XLEN +: XLEN] = {XLEN{1'b1}};
      end
      for (int q = p + 1; q < int'(WB_PORTS); q++) begin
        if (bus.wb_en[p] && bus.wb_en[q] && (bus.wb_reg[p*RW +: RW] == bus.wb_reg[q*RW +: RW]))
          conflict_c = 1'b1;
      end
    end
    if (bus.wb_flags_en) begin
      merge_data_c[EW-1 -: FLAGW] = bus.wb_flags;
      merge_mask_c[EW-1 -: FLAGW] = {FLAGW{1'b1}};
    end
  end

  // Write stage between the merge and the array
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen   <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      wmask <= '0;
    end else begin
      wen <= wr_c;
      if (wr_c) begin
        waddr <= bus.wb_thread;
        wdata <= merge_data_c;
        wmask <= merge_mask_c;
      end
    end
  end

  // Context array: cleared entry by entry in INIT, committed from the stage in RUN
  always_ff @(posedge clk) begin
    if (state == INIT)
      mem[cnt] <= '0;
    else if (wen)
      mem[waddr] <= (mem[waddr] & ~wmask) | wdata;
  end

  // Load path sees the array, then the stage, then this cycle's merge
  always_comb begin
    bypass_c = mem[bus.thread_start];
    if (wen && (waddr == bus.thread_start))
      bypass_c = (bypass_c & ~wmask) | wdata;
    if (wr_c && (bus.wb_thread == bus.thread_start))
      bypass_c = (bypass_c & ~merge_mask_c) | merge_data_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.regdata     <= '0;
      bus.au_flags    <= '0;
      bus.regdata_vld <= 1'b0;
      bus.wb_conflict <= 1'b0;
    end else begin
      bus.regdata_vld <= run_c && bus.thread_start_en;
      bus.wb_conflict <= run_c && conflict_c;
      if (run_c && bus.thread_start_en) begin
        bus.au_flags <= bypass_c[EW-1 -: FLAGW];
        bus.regdata  <= bypass_c[RDW-1:0];
      end
    end
  end
endmodule

// File: tb/tb_tawas_regfile_mt.sv
// Self-checking bench for tawas_regfile_mt: directed vector table, random traffic against
// a per-thread context model, and hand-written reset/clear sequences.
module tb_tawas_regfile_mt;
  localparam int unsigned THREADS  = 16;
  localparam int unsigned REGS     = 8;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned FLAGW    = 8;
  localparam int unsigned WB_PORTS = 3;

  typedef struct {
    logic        ld;
    logic [3:0]  ts;
    logic [3:0]  thr;
    logic [2:0]  en;
    logic [8:0]  regs;
    logic [95:0] data;
    logic        fen;
    logic [7:0]  fl;
    int          chk_reg;
    logic [31:0] chk_val;
    logic        chk_fl;
    logic [7:0]  chk_flags;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [31:0]  model_regs  [THREADS][REGS];
  logic [7:0]   model_flags [THREADS];
  logic [255:0] exp_regdata;
  logic [7:0]   exp_flags;
  vec_t         tbl [10];

  tawas_regfile_mt_if #(.THREADS(THREADS), .REGS(REGS), .XLEN(XLEN), .FLAGW(FLAGW),
                        .WB_PORTS(WB_PORTS)) bus ();

  tawas_regfile_mt #(.THREADS(THREADS), .REGS(REGS), .XLEN(XLEN), .FLAGW(FLAGW),
                     .WB_PORTS(WB_PORTS)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.thread_start_en = 1'b0;
    bus.thread_start    = '0;
    bus.wb_thread       = '0;
    bus.wb_en           = '0;
    bus.wb_reg          = '0;
    bus.wb_data         = '0;
    bus.wb_flags_en     = 1'b0;
    bus.wb_flags        = '0;
  endtask

  task automatic clear_model();
    for (int t = 0; t < int'(THREADS); t++) begin
      model_flags[t] = '0;
      for (int r = 0; r < int'(REGS); r++) model_regs[t][r] = '0;
    end
    exp_regdata = '0;
    exp_flags   = '0;
  endtask

  function automatic vec_t mk(input logic ld, input int ts, input int thr, input logic [2:0] en,
                              input logic [8:0] regs, input logic [95:0] data, input logic fen,
                              input logic [7:0] fl, input int chk_reg, input logic [31:0] chk_val,
                              input logic chk_fl, input logic [7:0] chk_flags);
    vec_t v;
    v.ld = ld; v.ts = 4'(ts); v.thr = 4'(thr); v.en = en; v.regs = regs; v.data = data;
    v.fen = fen; v.fl = fl; v.chk_reg = chk_reg; v.chk_val = chk_val;
    v.chk_fl = chk_fl; v.chk_flags = chk_flags;
    return v;
  endfunction

  // One RUN-mode cycle: every writeback issued so far is visible to a load in the same cycle
  task automatic apply(input vec_t v);
    logic conf;
    bus.thread_start_en = v.ld;
    bus.thread_start    = v.ts;
    bus.wb_thread       = v.thr;
    bus.wb_en           = v.en;
    bus.wb_reg          = v.regs;
    bus.wb_data         = v.data;
    bus.wb_flags_en     = v.fen;
    bus.wb_flags        = v.fl;
    conf = 1'b0;
    for (int p = 0; p < 3; p++)
      for (int q = p + 1; q < 3; q++)
        if (v.en[p] && v.en[q] && v.regs[p*3 +: 3] == v.regs[q*3 +: 3]) conf = 1'b1;
    for (int p = 0; p < 3; p++)
      if (v.en[p]) model_regs[v.thr][v.regs[p*3 +: 3]] = v.data[p*32 +: 32];
    if (v.fen) model_flags[v.thr] = v.fl;
    if (v.ld) begin
      for (int r = 0; r < int'(REGS); r++) exp_regdata[r*32 +: 32] = model_regs[v.ts][r];
      exp_flags = model_flags[v.ts];
    end
    @(posedge clk);
    #1;
    chk("regdata_vld", 256'(bus.regdata_vld), 256'(v.ld));
    chk("wb_conflict", 256'(bus.wb_conflict), 256'(conf));
    chk("regdata", bus.regdata, exp_regdata);
    chk("au_flags", 256'(bus.au_flags), 256'(exp_flags));
    if (v.chk_reg >= 0) chk("tbl_reg", 256'(bus.regdata[v.chk_reg*32 +: 32]), 256'(v.chk_val));
    if (v.chk_fl) chk("tbl_flags", 256'(bus.au_flags), 256'(v.chk_flags));
  endtask

  task automatic count_init(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.init_done) break;
    end
    chk(name, 256'(n), 256'(16));
  endtask

  initial begin
    vec_t v;
    idle_inputs();
    clear_model();

    #2;
    chk("rst_init_done", 256'(bus.init_done), 256'(0));
    chk("rst_regdata", bus.regdata, 256'(0));
    chk("rst_vld", 256'(bus.regdata_vld), 256'(0));
    chk("rst_conflict", 256'(bus.wb_conflict), 256'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    count_init("init_edges");

    // Load of a cleared thread, then an idle cycle to show the strobe is a single pulse
    apply(mk(1, 5, 0, 3'b000, 9'd0, 96'd0, 0, 8'h00, 0, 32'h0, 1, 8'h00));
    apply(mk(0, 0, 0, 3'b000, 9'd0, 96'd0, 0, 8'h00, -1, 32'h0, 0, 8'h00));

    tbl[0] = mk(0, 0, 2, 3'b001, 9'b000_000_011, {64'h0, 32'hDEADBEEF}, 0, 8'h00, -1, 32'h0, 0, 8'h00);
    tbl[1] = mk(0, 0, 0, 3'b000, 9'd0, 96'd0, 0, 8'h00, -1, 32'h0, 0, 8'h00);
    tbl[2] = mk(1, 2, 0, 3'b000, 9'd0, 96'd0, 0, 8'h00, 3, 32'hDEADBEEF, 0, 8'h00);
    tbl[3] = mk(1, 7, 7, 3'b010, 9'd0, {32'h0, 32'h11, 32'h0}, 1, 8'hA5, 0, 32'h11, 1, 8'hA5);
    tbl[4] = mk(0, 0, 4, 3'b001, 9'b000_000_111, {64'h0, 32'h55}, 0, 8'h00, -1, 32'h0, 0, 8'h00);
    tbl[5] = mk(1, 4, 0, 3'b000, 9'd0, 96'd0, 0, 8'h00, 7, 32'h55, 0, 8'h00);
    tbl[6] = mk(0, 0, 3, 3'b101, 9'b001_000_001, {32'h2, 32'h0, 32'h1}, 0, 8'h00, -1, 32'h0, 0, 8'h00);
    tbl[7] = mk(0, 0, 0, 3'b000, 9'd0, 96'd0, 0, 8'h00, -1, 32'h0, 0, 8'h00);
    tbl[8] = mk(1, 3, 0, 3'b000, 9'd0, 96'd0, 0, 8'h00, 1, 32'h2, 0, 8'h00);
    tbl[9] = mk(1, 2, 2, 3'b001, 9'd0, {64'h0, 32'h77}, 0, 8'h00, 3, 32'hDEADBEEF, 0, 8'h00);
    for (int i = 0; i < 10; i++) apply(tbl[i]);

    // Random traffic concentrated on a few threads so bypass paths are exercised
    for (int i = 0; i < 400; i++) begin
      v.ld   = 1'($urandom);
      v.ts   = 4'($urandom_range(0, 3));
      v.thr  = 4'($urandom_range(0, 3));
      v.en   = 3'($urandom);
      v.regs = 9'($urandom);
      v.data = {$urandom, $urandom, $urandom};
      v.fen  = 1'($urandom);
      v.fl   = 8'($urandom);
      v.chk_reg = -1; v.chk_val = '0; v.chk_fl = 1'b0; v.chk_flags = '0;
      apply(v);
    end

    // Reset with a write sitting in the stage
    idle_inputs();
    bus.wb_thread = 4'd6; bus.wb_en = 3'b001; bus.wb_reg = 9'd2; bus.wb_data = 96'h99;
    @(posedge clk);
    #1;
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("mid_rst_done", 256'(bus.init_done), 256'(0));
    chk("mid_rst_regdata", bus.regdata, 256'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();

    // Requests during INIT must produce no load and no conflict
    bus.thread_start_en = 1'b1; bus.thread_start = 4'd6;
    bus.wb_thread = 4'd1; bus.wb_en = 3'b101; bus.wb_reg = 9'b001_000_001; bus.wb_flags_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      chk("init_vld", 256'(bus.regdata_vld), 256'(0));
      chk("init_conflict", 256'(bus.wb_conflict), 256'(0));
    end
    chk("init9_done", 256'(bus.init_done), 256'(0));
    idle_inputs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    count_init("reinit_edges");

    apply(mk(1, 6, 0, 3'b000, 9'd0, 96'd0, 0, 8'h00, 2, 32'h0, 1, 8'h00));
    apply(mk(1, 2, 0, 3'b000, 9'd0, 96'd0, 0, 8'h00, 3, 32'h0, 0, 8'h00));
    apply(mk(1, 1, 0, 3'b000, 9'd0, 96'd0, 0, 8'h00, 1, 32'h0, 1, 8'h00));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tawas_regfile_mt.md
# tawas_regfile_mt

Parametrised multithreaded register file for the Tawas core: holds one architectural context (REGS general registers plus an AU flag field) per hardware thread. It loads a full thread context onto a flat bus on thread start and merges up to WB_PORTS register writebacks plus a flags writeback per cycle into a single thread's context. Relative to the previous generation it adds:

- generic thread, register and port counts
- a hardware clear sequence after reset
- read-after-write bypass
- a load-valid strobe
- a same-register writeback conflict flag

## Interface
- THREADS, 16, hardware thread count; power of two, ≥2; TW = clog2(THREADS)
- REGS, 8, registers per thread; power of two, ≥2; RW = clog2(REGS)
- XLEN, 32, register width
- FLAGW, 8, AU flag width
- WB_PORTS, 3, register writeback ports (AU, pointer, store in the default build)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- init_done  out  1  high once every thread context has been cleared
- thread_start_en  in  1  load context request
- thread_start  in  TW  thread to load
- regdata  out  REGS*XLEN  loaded registers; register r is at bits [r*XLEN +: XLEN]
- au_flags  out  FLAGW  loaded flags
- regdata_vld  out  1  one-cycle pulse, aligned with updated regdata/au_flags
- wb_thread  in  TW  thread targeted by all writebacks this cycle
- wb_en  in  WB_PORTS  per-port write enable
- wb_reg  in  WB_PORTS*RW  per-port register index; port p is at [p*RW +: RW]
- wb_data  in  WB_PORTS*XLEN  per-port data; port p is at [p*XLEN +: XLEN]
- wb_flags_en  in  1  flags write enable
- wb_flags  in  FLAGW  flags data
- wb_conflict  out  1  one-cycle pulse: two or more enabled ports targeted the same register

## Operation
- **Storage:** THREADS entries of FLAGW+REGS*XLEN bits.
- **Clear FSM:** states INIT and RUN.
  - rst forces INIT with the clear counter at 0.
  - In INIT, each clk edge writes all-zero to entry[counter] and increments the counter.
  - The edge that writes entry THREADS-1 sets init_done=1 and moves to RUN.
  - In INIT, thread_start_en, wb_en and wb_flags_en are ignored: no load, no stage capture, no conflict pulse.
- **Write merge** (combinational, RUN only):
  - Ports are applied in index order, p=0 first. Each enabled port ORs its data into its register slot through a mask.
  - On a register collision the higher index wins: its slot replaces the lower port's data. No OR-mixing of colliding data.
  - Flags use a separate mask field and never collide with ports.
- **Write stage:** when any enable is set in RUN, the stage captures wen=1, waddr=wb_thread, wdata and wmask. Otherwise wen<=0.
- **Commit:** when wen=1, entry[waddr] <= (entry & ~wmask) | wdata.
- **Load:** on thread_start_en in RUN, {au_flags, regdata} <= bypassed value of entry[thread_start]. Bypass priority, each merge applied only if its thread matches:
  1. current-cycle writeback merge (wb_thread == thread_start)
  2. stage register (wen && waddr == thread_start)
  3. array
- **Hold:** regdata and au_flags hold their value when no load occurs.
- **Conflict flag:** wb_conflict <= 1 for one cycle when any two enabled ports carry equal wb_reg. It does not block the write.

## Timing
- **Reset values:** regdata=0, au_flags=0, regdata_vld=0, init_done=0, wb_conflict=0, wen=0, clear counter=0, state INIT.
- **Clear sequence:** init_done rises on the THREADS-th rising edge after rst deasserts.
- **Load latency:** 1. A request in cycle N gives regdata and regdata_vld=1 in cycle N+1.
- **Writeback visibility:**
  - Through a load: a load issued in the same cycle as the writeback returns the new value (zero-cycle visibility).
  - In the array: the array holds the value 2 edges after the writeback.
- **Back-to-back:** writes to the same thread in consecutive cycles both land. A load between them returns the first write merged with the second only if both are in bypass scope that cycle.
- **Continuous traffic:** loads and writebacks can be issued every cycle; there is no stall or backpressure.
- **Reset mid-operation:** the pending stage write is discarded (wen=0) and the clear sequence restarts from thread 0. Prior contents become zero after the sequence completes.

## Test plan
- **Reset clear:** reset, then count edges -> init_done rises exactly at edge 16. A load of thread 5 then returns regdata=0, au_flags=0 and regdata_vld pulses once.
- **Single write then load:** write port0 reg3=0xDEADBEEF on thread 2, then load thread 2 two cycles later -> regdata[127:96]=0xDEADBEEF, other registers 0.
- **Same-cycle bypass:** in one cycle, wb_thread=7 with port1 reg0=0x11 and flags=0xA5, plus thread_start=7 -> next cycle regdata[31:0]=0x11, au_flags=0xA5.
- **Stage bypass:** write thread 4 reg7=0x55 in cycle N, load thread 4 in cycle N+1 -> regdata[255:224]=0x55.
- **Conflict:** ports 0 and 2 both write reg1 of thread 3 (0x1, 0x2) -> wb_conflict pulses once and a later load gives reg1=0x2.
- **Reset mid-operation:** assert rst during INIT at counter 9 and during a pending stage write -> counter restarts at 0, the write is lost, and init_done stays 0 until 16 edges after the second reset releases.
